mem_port_arbiter: RTL

//  Shares one memory bus (req/gnt/rvalid handshake) between the fetch stage (instr port)
//  and the load/store unit (data port). Round-robin arbitration, one outstanding

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, LSU, flush and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              instr_req_in;
  logic [ADDR_W-1:0] instr_addr_in;
  logic              instr_gnt_out;
  logic              instr_rvalid_out;
  logic [DATA_W-1:0] instr_rdata_out;
  logic              data_req_in;
  logic              data_we_in;
  logic [DATA_W/8-1:0] data_be_in;
  logic [ADDR_W-1:0] data_addr_in;
  logic [DATA_W-1:0] data_wdata_in;
  logic              data_gnt_out;
  logic              data_rvalid_out;
  logic [DATA_W-1:0] data_rdata_out;
  logic              flush_in;
  logic              bus_err_out;
  logic              mem_req_out;
  logic              mem_we_out;
  logic [DATA_W/8-1:0] mem_be_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic              mem_gnt_in;
  logic              mem_rvalid_in;
  logic [DATA_W-1:0] mem_rdata_in;
  modport slave (
    input  instr_req_in, instr_addr_in, data_req_in, data_we_in, data_be_in, data_addr_in,
           data_wdata_in, flush_in, mem_gnt_in, mem_rvalid_in, mem_rdata_in,
    output instr_gnt_out, instr_rvalid_out, instr_rdata_out, data_gnt_out, data_rvalid_out,
           data_rdata_out, bus_err_out, mem_req_out, mem_we_out, mem_be_out, mem_addr_out,
           mem_wdata_out
  );
  modport master (
    output instr_req_in, instr_addr_in, data_req_in, data_we_in, data_be_in, data_addr_in,
           data_wdata_in, flush_in, mem_gnt_in, mem_rvalid_in, mem_rdata_in,
    input  instr_gnt_out, instr_rvalid_out, instr_rdata_out, data_gnt_out, data_rvalid_out,
           data_rdata_out, bus_err_out, mem_req_out, mem_we_out, mem_be_out, mem_addr_out,
           mem_wdata_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory bus between fetch and LSU, with flush drop and response timeout.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk_in,
  input logic rst_in,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  state_t              state_q, state_d;
  logic                owner_q, owner_d, last_win_q, last_win_d, drop_q, drop_d;
  logic [7:0]          timer_q, timer_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_req, win, gnt, rsp, tmo, fin;
  // owner/last_win encoding: 0 = INSTR, 1 = DATA
  always_comb begin
    i_req = bus.instr_req_in & ~bus.flush_in;
    win   = bus.data_req_in & (~i_req | ~last_win_q);
    gnt   = (state_q == REQ) & bus.mem_gnt_in;
    rsp   = (state_q == RESP) & bus.mem_rvalid_in;
    tmo   = (state_q == RESP) & ~bus.mem_rvalid_in & (timer_q == TO_LAST);
    fin   = rsp | tmo;
    state_d     = state_q;
    owner_d     = owner_q;
    last_win_d  = last_win_q;
    drop_d      = drop_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: if (i_req | bus.data_req_in) begin
        owner_d     = win;
        mem_req_d   = 1'b1;
        mem_we_d    = win & bus.data_we_in;
        mem_be_d    = win ? bus.data_be_in : '1;
        mem_addr_d  = win ? bus.data_addr_in : bus.instr_addr_in;
        mem_wdata_d = win ? bus.data_wdata_in : '0;
        state_d     = REQ;
      end
      REQ: begin
        drop_d = drop_q | (bus.flush_in & ~owner_q);
        if (gnt) begin
          mem_req_d  = 1'b0;
          last_win_d = owner_q;
          timer_d    = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        drop_d  = fin ? 1'b0 : drop_q | (bus.flush_in & ~owner_q);
        timer_d = (timer_q == 8'hff) ? timer_q : timer_q + 8'd1;
        state_d = fin ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.instr_gnt_out    = gnt & ~owner_q;
    bus.data_gnt_out     = gnt & owner_q;
    bus.instr_rvalid_out = fin & ~owner_q & ~drop_q;
    bus.data_rvalid_out  = fin & owner_q;
    bus.instr_rdata_out  = (rsp & ~owner_q & ~drop_q) ? bus.mem_rdata_in : '0;
    bus.data_rdata_out   = (rsp & owner_q) ? bus.mem_rdata_in : '0;
    bus.bus_err_out      = tmo;
    bus.mem_req_out      = mem_req_q;
    bus.mem_we_out       = mem_we_q;
    bus.mem_be_out       = mem_be_q;
    bus.mem_addr_out     = mem_addr_q;
    bus.mem_wdata_out    = mem_wdata_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_win_q  <= 1'b0;
      drop_q      <= 1'b0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_win_q  <= last_win_d;
      drop_q      <= drop_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule
